// File: rtl/pong_match_ctrl_if.sv
// Signal bundle between the pong match sequencer and the rest of pong_game:
// the ball/paddle/frame flags in and the match status out.
interface pong_match_ctrl_if;
    logic       endofframe;
    logic       isMoving;
    logic [1:0] missed;
    logic [1:0] collided;
    logic       restart;
    logic [3:0] score_one;
    logic [3:0] score_two;
    logic [7:0] hit_count;
    logic [1:0] winner;
    logic [2:0] state;
    logic       point_pulse;

    modport master (
        output endofframe, isMoving, missed, collided,
        input  restart, score_one, score_two, hit_count, winner, state, point_pulse
    );

    modport slave (
        input  endofframe, isMoving, missed, collided,
        output restart, score_one, score_two, hit_count, winner, state, point_pulse
    );
endinterface

// File: rtl/pong_match_ctrl.sv
// Match sequencer for pong_game: IDLE -> SERVE -> PLAY -> POINT -> (SERVE | OVER -> IDLE),
// keeping scores, rally hit count and winner, with pauses timed in video frames.
module pong_match_ctrl #(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int OVER_FRAMES  = 180,
    parameter int TIMER_W      = 8
) (
    input logic               clk50M,
    input logic               reset,
    pong_match_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'b000,
        SERVE = 3'b001,
        PLAY  = 3'b010,
        POINT = 3'b011,
        OVER  = 3'b100
    } state_t;

    localparam logic [3:0] WIN = 4'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [3:0]         score_one_q, score_one_d;
    logic [3:0]         score_two_q, score_two_d;
    logic [7:0]         hit_q, hit_d;
    logic [1:0]         winner_q, winner_d;
    logic               restart_q, restart_d;
    logic               pulse_q, pulse_d;
    logic               endofframe_q;
    logic [1:0]         collided_q;

    logic       frame_tick;
    logic       timer_done;
    logic [1:0] collided_rise;

    assign frame_tick    = bus.endofframe & ~endofframe_q;
    assign timer_done    = (timer_q == '0);
    assign collided_rise = bus.collided & ~collided_q;

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        score_one_d = score_one_q;
        score_two_d = score_two_q;
        hit_d       = hit_q;
        winner_d    = winner_q;
        pulse_d     = 1'b0;

        if (frame_tick && !timer_done)
            timer_d = timer_q - 1'b1;

        case (state_q)
            IDLE: begin
                if (bus.isMoving) begin
                    score_one_d = '0;
                    score_two_d = '0;
                    winner_d    = 2'b00;
                    hit_d       = '0;
                    state_d     = SERVE;
                end
            end
            SERVE: begin
                hit_d = '0;
                if (timer_done && bus.isMoving)
                    state_d = PLAY;
            end
            PLAY: begin
                // A miss ends the rally, so a collision on the same cycle is dropped.
                if (bus.missed != 2'b00) begin
                    pulse_d = 1'b1;
                    state_d = POINT;
                    if (bus.missed == 2'b01 && score_two_q < WIN)
                        score_two_d = score_two_q + 4'd1;
                    if (bus.missed == 2'b10 && score_one_q < WIN)
                        score_one_d = score_one_q + 4'd1;
                end else if (collided_rise != 2'b00 && hit_q != 8'hFF) begin
                    hit_d = hit_q + 8'd1;
                end
            end
            POINT: begin
                if (timer_done) begin
                    if (score_one_q == WIN || score_two_q == WIN) begin
                        state_d  = OVER;
                        winner_d = (score_one_q == WIN) ? 2'b01 : 2'b10;
                    end else begin
                        state_d = SERVE;
                    end
                end
            end
            OVER: begin
                if (timer_done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Entry into a timed state reloads its pause; a tick on the same cycle is superseded.
        if (state_d != state_q) begin
            case (state_d)
                SERVE:   timer_d = TIMER_W'(SERVE_FRAMES);
                POINT:   timer_d = TIMER_W'(POINT_FRAMES);
                OVER:    timer_d = TIMER_W'(OVER_FRAMES);
                default: timer_d = '0;
            endcase
        end

        restart_d = (state_d != PLAY);
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk50M) begin
        if (reset) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            score_one_q  <= '0;
            score_two_q  <= '0;
            hit_q        <= '0;
            winner_q     <= 2'b00;
            restart_q    <= 1'b1;
            pulse_q      <= 1'b0;
            endofframe_q <= 1'b0;
            collided_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            score_one_q  <= score_one_d;
            score_two_q  <= score_two_d;
            hit_q        <= hit_d;
            winner_q     <= winner_d;
            restart_q    <= restart_d;
            pulse_q      <= pulse_d;
            endofframe_q <= bus.endofframe;
            collided_q   <= bus.collided;
        end
    end

    assign bus.state       = state_q;
    assign bus.restart     = restart_q;
    assign bus.score_one   = score_one_q;
    assign bus.score_two   = score_two_q;
    assign bus.hit_count   = hit_q;
    assign bus.winner      = winner_q;
    assign bus.point_pulse = pulse_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Directed bench for pong_match_ctrl: serve timing, hit counting, scoring, match end,
// frame-tick edge detection and miss/collision precedence.
module tb_pong_match_ctrl;

    logic clk50M;
    logic reset;
    int   checks;
    int   failures;

    pong_match_ctrl_if bus ();

    pong_match_ctrl dut (
        .clk50M (clk50M),
        .reset  (reset),
        .bus    (bus)
    );

    initial clk50M = 1'b0;
    always #10 clk50M = ~clk50M;

    task automatic step(input int n);
        repeat (n) @(posedge clk50M);
        #1;
    endtask

    // One rising edge of endofframe followed by one low cycle.
    task automatic frame_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.endofframe = 1'b1;
            step(1);
            bus.endofframe = 1'b0;
            step(1);
        end
    endtask

    task automatic serve_to_play();
        bus.isMoving = 1'b1;
        frame_ticks(60);
        bus.isMoving = 1'b0;
    endtask

    task automatic go_to_play();
        bus.isMoving = 1'b1;
        step(1);
        serve_to_play();
    endtask

    task automatic score_point(input logic [1:0] m);
        bus.missed = m;
        step(1);
        bus.missed = 2'b00;
        frame_ticks(90);
        serve_to_play();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(3);
        checks++;
        if (bus.state !== 3'b000) begin failures++; $display("FAIL por_state got=%b exp=000", bus.state); end
        checks++;
        if (bus.restart !== 1'b1 || bus.point_pulse !== 1'b0) begin
            failures++; $display("FAIL por_flags restart=%b pulse=%b exp=1,0", bus.restart, bus.point_pulse);
        end
        checks++;
        if (bus.score_one !== 4'd0 || bus.score_two !== 4'd0 || bus.hit_count !== 8'd0 || bus.winner !== 2'b00) begin
            failures++;
            $display("FAIL por_counts s1=%0d s2=%0d hits=%0d win=%b exp=0,0,0,00",
                     bus.score_one, bus.score_two, bus.hit_count, bus.winner);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_serve();
        bus.isMoving = 1'b1;
        step(1);
        checks++;
        if (bus.state !== 3'b001 || bus.restart !== 1'b1) begin
            failures++; $display("FAIL serve_entry state=%b restart=%b exp=001,1", bus.state, bus.restart);
        end
        frame_ticks(59);
        checks++;
        if (bus.state !== 3'b001) begin failures++; $display("FAIL serve_59_ticks state=%b exp=001", bus.state); end
        frame_ticks(1);
        checks++;
        if (bus.state !== 3'b010 || bus.restart !== 1'b0) begin
            failures++; $display("FAIL serve_to_play state=%b restart=%b exp=010,0", bus.state, bus.restart);
        end
        bus.isMoving = 1'b0;

        reset = 1'b1;
        step(1);
        reset = 1'b0;
        bus.isMoving = 1'b1;
        step(1);
        bus.isMoving = 1'b0;
        frame_ticks(60);
        step(5);
        checks++;
        if (bus.state !== 3'b001 || bus.restart !== 1'b1) begin
            failures++; $display("FAIL serve_wait state=%b restart=%b exp=001,1", bus.state, bus.restart);
        end
        bus.isMoving = 1'b1;
        step(1);
        checks++;
        if (bus.state !== 3'b010) begin failures++; $display("FAIL serve_late_move state=%b exp=010", bus.state); end
        bus.isMoving = 1'b0;
    endtask

    task automatic test_hits_and_miss();
        int pulses;
        checks++;
        if (bus.hit_count !== 8'd0) begin failures++; $display("FAIL hits_start got=%0d exp=0", bus.hit_count); end
        bus.collided = 2'b01;
        step(5);
        checks++;
        if (bus.hit_count !== 8'd1) begin failures++; $display("FAIL hits_left_held got=%0d exp=1", bus.hit_count); end
        bus.collided = 2'b00;
        step(1);
        bus.collided = 2'b10;
        step(5);
        checks++;
        if (bus.hit_count !== 8'd2) begin failures++; $display("FAIL hits_right got=%0d exp=2", bus.hit_count); end
        bus.collided = 2'b00;
        step(1);
        bus.collided = 2'b11;
        step(1);
        bus.collided = 2'b00;
        checks++;
        if (bus.hit_count !== 8'd3) begin failures++; $display("FAIL hits_both got=%0d exp=3", bus.hit_count); end

        pulses = 0;
        bus.missed = 2'b01;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (bus.point_pulse === 1'b1) pulses++;
        end
        bus.missed = 2'b00;
        checks++;
        if (pulses != 1) begin failures++; $display("FAIL miss_pulses got=%0d exp=1", pulses); end
        checks++;
        if (bus.score_two !== 4'd1 || bus.score_one !== 4'd0 || bus.state !== 3'b011) begin
            failures++;
            $display("FAIL miss_score s1=%0d s2=%0d state=%b exp=0,1,011", bus.score_one, bus.score_two, bus.state);
        end
        frame_ticks(90);
        step(1);
        checks++;
        if (bus.state !== 3'b001 || bus.hit_count !== 8'd0) begin
            failures++; $display("FAIL point_to_serve state=%b hits=%0d exp=001,0", bus.state, bus.hit_count);
        end
    endtask

    task automatic test_reset_mid_play();
        serve_to_play();
        for (int i = 0; i < 3; i++) score_point(2'b10);
        checks++;
        if (bus.score_one !== 4'd3 || bus.state !== 3'b010) begin
            failures++; $display("FAIL pre_reset s1=%0d state=%b exp=3,010", bus.score_one, bus.state);
        end
        reset = 1'b1;
        step(3);
        checks++;
        if (bus.state !== 3'b000 || bus.score_one !== 4'd0 || bus.score_two !== 4'd0 ||
            bus.restart !== 1'b1 || bus.winner !== 2'b00 || bus.point_pulse !== 1'b0) begin
            failures++;
            $display("FAIL mid_play_reset state=%b s1=%0d s2=%0d restart=%b win=%b pulse=%b exp=000,0,0,1,00,0",
                     bus.state, bus.score_one, bus.score_two, bus.restart, bus.winner, bus.point_pulse);
        end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_win();
        go_to_play();
        for (int i = 0; i < 6; i++) score_point(2'b10);
        checks++;
        if (bus.score_one !== 4'd6) begin failures++; $display("FAIL win_pre got=%0d exp=6", bus.score_one); end
        bus.missed = 2'b10;
        step(1);
        bus.missed = 2'b00;
        checks++;
        if (bus.score_one !== 4'd7 || bus.state !== 3'b011 || bus.point_pulse !== 1'b1) begin
            failures++;
            $display("FAIL win_point s1=%0d state=%b pulse=%b exp=7,011,1", bus.score_one, bus.state, bus.point_pulse);
        end
        frame_ticks(89);
        checks++;
        if (bus.state !== 3'b011) begin failures++; $display("FAIL win_point_89 state=%b exp=011", bus.state); end
        frame_ticks(1);
        checks++;
        if (bus.state !== 3'b100 || bus.winner !== 2'b01) begin
            failures++; $display("FAIL win_over state=%b win=%b exp=100,01", bus.state, bus.winner);
        end
        frame_ticks(179);
        checks++;
        if (bus.state !== 3'b100) begin failures++; $display("FAIL over_179 state=%b exp=100", bus.state); end
        frame_ticks(1);
        checks++;
        if (bus.state !== 3'b000 || bus.score_one !== 4'd7 || bus.restart !== 1'b1) begin
            failures++;
            $display("FAIL over_to_idle state=%b s1=%0d restart=%b exp=000,7,1", bus.state, bus.score_one, bus.restart);
        end
        bus.isMoving = 1'b1;
        step(1);
        bus.isMoving = 1'b0;
        checks++;
        if (bus.state !== 3'b001 || bus.score_one !== 4'd0 || bus.winner !== 2'b00) begin
            failures++;
            $display("FAIL new_match state=%b s1=%0d win=%b exp=001,0,00", bus.state, bus.score_one, bus.winner);
        end
    endtask

    task automatic test_double_miss_and_level();
        serve_to_play();
        bus.missed = 2'b11;
        step(1);
        bus.missed = 2'b00;
        checks++;
        if (bus.state !== 3'b011 || bus.point_pulse !== 1'b1 || bus.score_one !== 4'd0 || bus.score_two !== 4'd0) begin
            failures++;
            $display("FAIL double_miss state=%b pulse=%b s1=%0d s2=%0d exp=011,1,0,0",
                     bus.state, bus.point_pulse, bus.score_one, bus.score_two);
        end
        bus.endofframe = 1'b1;
        step(1000);
        bus.endofframe = 1'b0;
        step(1);
        frame_ticks(88);
        checks++;
        if (bus.state !== 3'b011) begin failures++; $display("FAIL level_tick_89 state=%b exp=011", bus.state); end
        frame_ticks(1);
        checks++;
        if (bus.state !== 3'b001) begin failures++; $display("FAIL level_tick_90 state=%b exp=001", bus.state); end
    endtask

    task automatic test_same_cycle();
        serve_to_play();
        bus.collided = 2'b01;
        bus.missed   = 2'b01;
        step(1);
        bus.collided = 2'b00;
        bus.missed   = 2'b00;
        checks++;
        if (bus.hit_count !== 8'd0 || bus.score_two !== 4'd1 || bus.state !== 3'b011) begin
            failures++;
            $display("FAIL miss_beats_hit hits=%0d s2=%0d state=%b exp=0,1,011",
                     bus.hit_count, bus.score_two, bus.state);
        end
        step(1);
        checks++;
        if (bus.point_pulse !== 1'b0) begin failures++; $display("FAIL pulse_width got=%b exp=0", bus.point_pulse); end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        bus.endofframe = 1'b0;
        bus.isMoving   = 1'b0;
        bus.missed     = 2'b00;
        bus.collided   = 2'b00;
        test_reset();
        test_serve();
        test_hits_and_miss();
        test_reset_mid_play();
        test_win();
        test_double_miss_and_level();
        test_same_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
